mlp_feeder: RTL and testbench

Upstream sequencer for one PE lane of the MLP datapath. It captures one input-activation vector into a local buffer, then streams weight/activation pairs into the PE, one pair per accepted weight. The vector is replayed once per output neuron, and the last product of each neuron is flagged so the PE can close its accumulation. It sits between the layer-level memory/DMA interface and the PE's `weight`/`iact` inputs.

---
 rtl/mlp_feeder_if.sv | 30 +++
 rtl/mlp_feeder.sv | 130 +++++++++++++
 tb/tb_mlp_feeder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mlp_feeder_if.sv
// Handshake and PE-facing bundle for one mlp_feeder lane.
// A beat transfers on a rising edge where valid and ready are both high; ready never depends on valid.
interface mlp_feeder_if #(
   parameter int N = 8
);
   logic         start;
   logic [N-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] w_data;
   logic         w_valid;
   logic         w_ready;
   logic [N-1:0] weight_out;
   logic [N-1:0] iact_out;
   logic         pe_valid;
   logic         pe_last;
   logic         busy;
   logic         done;
   logic [1:0]   state;

   modport master (
      output start, in_data, in_valid, w_data, w_valid,
      input  in_ready, w_ready, weight_out, iact_out, pe_valid, pe_last, busy, done, state
   );

   modport slave (
      input  start, in_data, in_valid, w_data, w_valid,
      output in_ready, w_ready, weight_out, iact_out, pe_valid, pe_last, busy, done, state
   );
endinterface

// File: rtl/mlp_feeder.sv
// Captures one activation vector, then replays it once per output neuron against
// the incoming weight stream, flagging the final beat of each neuron for the PE.
module mlp_feeder #(
   parameter int N       = 8,
   parameter int DEPTH   = 16,
   parameter int NEURONS = 4
) (
   input  logic        clk,
   input  logic        rst,
   mlp_feeder_if.slave bus
);
   localparam int KW = $clog2(DEPTH);
   localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);
   localparam logic [NW-1:0] N_LAST = NW'(NEURONS - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [KW-1:0] load_cnt_q, load_cnt_d;
   logic [KW-1:0] k_cnt_q, k_cnt_d;
   logic [NW-1:0] n_cnt_q, n_cnt_d;
   logic [N-1:0]  weight_q, weight_d;
   logic [N-1:0]  iact_q, iact_d;
   logic          pe_valid_q, pe_valid_d;
   logic          pe_last_q, pe_last_d;
   logic [N-1:0]  act_buf_q [DEPTH];

   logic in_acc;
   logic w_acc;

   // Ready is a pure state decode, so accepts never form a loop through the sources.
   assign in_acc = bus.in_valid && (state_q == S_LOAD);
   assign w_acc  = bus.w_valid  && (state_q == S_STREAM);

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      k_cnt_d    = k_cnt_q;
      n_cnt_d    = n_cnt_q;
      weight_d   = weight_q;
      iact_d     = iact_q;
      pe_valid_d = 1'b0;
      pe_last_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               load_cnt_d = '0;
               k_cnt_d    = '0;
               n_cnt_d    = '0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_acc) begin
               if (load_cnt_q == K_LAST) begin
                  load_cnt_d = '0;
                  state_d    = S_STREAM;
               end else begin
                  load_cnt_d = load_cnt_q + 1'b1;
               end
            end
         end
         S_STREAM: begin
            if (w_acc) begin
               weight_d   = bus.w_data;
               iact_d     = act_buf_q[k_cnt_q];
               pe_valid_d = 1'b1;
               pe_last_d  = (k_cnt_q == K_LAST);
               if (k_cnt_q == K_LAST) begin
                  k_cnt_d = '0;
                  if (n_cnt_q == N_LAST) begin
                     n_cnt_d = '0;
                     state_d = S_DONE;
                  end else begin
                     n_cnt_d = n_cnt_q + 1'b1;
                  end
               end else begin
                  k_cnt_d = k_cnt_q + 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         load_cnt_q <= '0;
         k_cnt_q    <= '0;
         n_cnt_q    <= '0;
         weight_q   <= '0;
         iact_q     <= '0;
         pe_valid_q <= 1'b0;
         pe_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         k_cnt_q    <= k_cnt_d;
         n_cnt_q    <= n_cnt_d;
         weight_q   <= weight_d;
         iact_q     <= iact_d;
         pe_valid_q <= pe_valid_d;
         pe_last_q  <= pe_last_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) act_buf_q[i] <= '0;
      end else if (in_acc) begin
         act_buf_q[load_cnt_q] <= bus.in_data;
      end
   end

   assign bus.in_ready   = (state_q == S_LOAD);
   assign bus.w_ready    = (state_q == S_STREAM);
   assign bus.weight_out = weight_q;
   assign bus.iact_out   = iact_q;
   assign bus.pe_valid   = pe_valid_q;
   assign bus.pe_last    = pe_last_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.state      = state_q;
endmodule

// File: tb/tb_mlp_feeder.sv
// Directed bench for mlp_feeder (N=8, DEPTH=4, NEURONS=2): table of layer passes
// plus hand-written reset sequences.
module tb_mlp_feeder;
   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   mlp_feeder_if #(.N(8)) bus ();

   mlp_feeder #(.N(8), .DEPTH(4), .NEURONS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic [3:0][7:0] act;
      logic [7:0][7:0] wt;
      logic [7:0][7:0] exp_a;
      int              w_gap_after;
      bit              in_toggle;
      bit              start_pokes;
   } pass_t;

   pass_t       tbl[5];
   logic [17:0] exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({bus.state, bus.weight_out, bus.iact_out, bus.pe_valid, bus.pe_last,
                  bus.done, bus.busy, bus.in_ready, bus.w_ready});
   endfunction

   task automatic idle_inputs();
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.w_valid  = 1'b0;
      bus.w_data   = 8'h00;
   endtask

   task automatic run_pass(input pass_t p);
      logic [17:0] e;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check({p.name, "/start"}, 32'({bus.busy, bus.in_ready, bus.w_ready}), 32'(3'b110));
      if (p.in_toggle) begin
         bus.w_valid = 1'b1;
         bus.w_data  = 8'hEE;
      end
      for (int j = 0; j < 4; j++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = p.act[j];
         tick();
         if (j < 3) check({p.name, "/load"}, 32'({bus.in_ready, bus.w_ready, bus.pe_valid}), 32'(3'b100));
         if (p.in_toggle && j < 3) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'hFF;
            tick();
            check({p.name, "/load_gap"}, 32'({bus.in_ready, bus.w_ready, bus.pe_valid}), 32'(3'b100));
         end
      end
      bus.in_valid = 1'b0;
      bus.w_valid  = 1'b0;
      check({p.name, "/stream_entry"}, 32'({bus.in_ready, bus.w_ready, bus.pe_valid}), 32'(3'b010));
      for (int j = 0; j < 8; j++) begin
         bus.start = p.start_pokes && (j == 4);
         if (p.in_toggle) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hAA;
         end
         bus.w_valid = 1'b1;
         bus.w_data  = p.wt[j];
         exp_q.push_back({(j == 7), ((j % 4) == 3), p.wt[j], p.exp_a[j]});
         tick();
         bus.start = 1'b0;
         e = exp_q.pop_front();
         check({p.name, "/pair"},
               32'({bus.pe_valid, bus.done, bus.pe_last, bus.weight_out, bus.iact_out}),
               32'({1'b1, e}));
         if (j == p.w_gap_after) begin
            repeat (2) begin
               bus.w_valid = 1'b0;
               tick();
               check({p.name, "/stall"}, 32'({bus.pe_valid, bus.pe_last, bus.done, bus.weight_out}),
                     32'({3'b000, p.wt[j]}));
            end
         end
      end
      idle_inputs();
      bus.start = p.start_pokes;
      check({p.name, "/done_busy"}, 32'(bus.busy), 32'd1);
      tick();
      bus.start = 1'b0;
      check({p.name, "/idle_after"},
            32'({bus.state, bus.busy, bus.done, bus.pe_valid, bus.in_ready, bus.w_ready}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      tbl[0] = '{name: "full", act: {8'd9, 8'd7, 8'd5, 8'd3},
                 wt: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                 exp_a: {8'd9, 8'd7, 8'd5, 8'd3, 8'd9, 8'd7, 8'd5, 8'd3},
                 w_gap_after: -1, in_toggle: 1'b0, start_pokes: 1'b0};
      tbl[1] = '{name: "wstall", act: {8'd9, 8'd7, 8'd5, 8'd3},
                 wt: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                 exp_a: {8'd9, 8'd7, 8'd5, 8'd3, 8'd9, 8'd7, 8'd5, 8'd3},
                 w_gap_after: 1, in_toggle: 1'b0, start_pokes: 1'b0};
      tbl[2] = '{name: "cross", act: {8'd40, 8'd30, 8'd20, 8'd10},
                 wt: {8'd18, 8'd17, 8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11},
                 exp_a: {8'd40, 8'd30, 8'd20, 8'd10, 8'd40, 8'd30, 8'd20, 8'd10},
                 w_gap_after: -1, in_toggle: 1'b1, start_pokes: 1'b0};
      tbl[3] = '{name: "ign_start", act: {8'd1, 8'd2, 8'd3, 8'd4},
                 wt: {8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9},
                 exp_a: {8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4},
                 w_gap_after: -1, in_toggle: 1'b0, start_pokes: 1'b1};
      tbl[4] = '{name: "post_reset", act: {8'd1, 8'd1, 8'd1, 8'd1},
                 wt: {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2},
                 exp_a: {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1},
                 w_gap_after: -1, in_toggle: 1'b0, start_pokes: 1'b0};

      // Reset held with random input activity.
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         bus.start    = 1'($urandom_range(1, 0));
         bus.in_valid = 1'($urandom_range(1, 0));
         bus.in_data  = 8'($urandom_range(255, 0));
         bus.w_valid  = 1'($urandom_range(1, 0));
         bus.w_data   = 8'($urandom_range(255, 0));
         tick();
         check("reset_outs", all_outs(), 32'd0);
      end
      idle_inputs();
      rst = 1'b1;
      tick();
      check("idle_after_reset", all_outs(), 32'd0);

      for (int i = 0; i < 4; i++) run_pass(tbl[i]);

      // Asynchronous reset in the middle of STREAM.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int j = 0; j < 4; j++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(5 + j);
         tick();
      end
      bus.in_valid = 1'b0;
      for (int j = 0; j < 2; j++) begin
         bus.w_valid = 1'b1;
         bus.w_data  = 8'(3 + j);
         tick();
      end
      bus.w_valid = 1'b0;
      check("pre_reset_pair", 32'({bus.pe_valid, bus.weight_out, bus.iact_out}), 32'({1'b1, 8'd4, 8'd6}));
      rst = 1'b0;
      #1;
      check("async_reset", all_outs(), 32'd0);
      tick();
      check("reset_hold", all_outs(), 32'd0);
      rst = 1'b1;
      tick();
      check("idle_after_mid_reset", all_outs(), 32'd0);

      run_pass(tbl[4]);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
